pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 17: width of the period and high-time counters; 17 covers the longest PWM frame the team's generator produces (256 x 256 cycles).
REQ-002 cclk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pwm_in  input  1  PWM waveform, asynchronous to cclk.
REQ-005 duty_cycle  output  8  last measured duty, 0..255 scale (same scale as the PWM generator's duty_cycle).
REQ-006 period  output  CNT_W  last measured rise-to-rise period, in cclk cycles.
REQ-007 high_time  output  CNT_W  last measured high time, in cclk cycles.
REQ-008 meas_valid  output  1  one-cycle pulse; duty_cycle, period and high_time were updated this cycle.
REQ-009 stuck  output  1  level; no edge seen within timeout.
REQ-010 overrun  output  1  one-cycle pulse; a measurement was dropped.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer plus one history flop; rise/fall are detected from synchronized-stage vs history-stage.
REQ-012 FSM states SHALL be: WAIT_RISE (after reset/timeout), HIGH, LOW.
  - WAIT_RISE -> HIGH on first rise; no measurement is published for this rise.
  - HIGH -> LOW on fall.
  - LOW -> HIGH on rise; publishes a measurement.
REQ-013 Counting SHALL work as follows.
  - The period counter clears to 1 on each rise and increments every cycle.
  - The high counter latches the period count at fall.
  - Both are exact cycle counts for a waveform synchronous to cclk.
REQ-014 On a rise in LOW, period and high_time SHALL be captured into holding registers, and an 8-iteration sequential restoring divider SHALL start, computing duty = floor(high_time*256/period).
  - The quotient fits in 8 bits because high_time < period.
REQ-015 Latency: meas_valid SHALL assert exactly 11 cclk edges after the edge at which pwm_in is first sampled high, for the rise that completes a period.
  - Outputs update at that edge.
REQ-016 Outputs SHALL hold their value between meas_valid pulses.
REQ-017 A rise while the divider is busy (period < 10) SHALL discard the in-flight result, pulse overrun, and restart on the new capture; counting is never interrupted.
REQ-018 Timeout: if the period counter reaches all-ones, the following SHALL happen.
  - stuck asserts.
  - duty_cycle becomes 255 if the synchronized level is high, 0 if low.
  - period and high_time become 0.
  - meas_valid pulses once.
  - FSM enters WAIT_RISE.
REQ-019 stuck SHALL deassert at the next rise.
REQ-020 Counters SHALL saturate, never wrap.

Reset
REQ-021 While rst is high, all outputs SHALL be 0, synchronizer flops 0, FSM WAIT_RISE, divider idle.
REQ-022 Reset asserted mid-divide SHALL cancel the result with no meas_valid.
REQ-023 After rst deasserts, the first rise SHALL only arm the FSM (REQ-012).

Structure
REQ-024 A shared package SHALL hold the FSM state enumeration, the divider iteration count (8) and the duty full-scale constant (255).
REQ-025 The divider SHALL be a sub-module, pwm_duty_div, with start/busy/done handshake.
  - Inputs: numerator and denominator (CNT_W).
  - Output: quotient (8).
  - done pulses 8 cycles after start.

Verification
REQ-026 rst high 5 cycles with pwm_in toggling -> all outputs 0, no meas_valid.
REQ-027 Generator-style waveform, period 256, high 64, cclk-synchronous -> first meas_valid 11 cycles after second rise: duty 64, period 256, high_time 64; repeats every 256 cycles.
REQ-028 Period 1000, high 333 -> duty 85, period 1000, high_time 333.
REQ-029 pwm_in held high for 2^17 cycles after a valid measurement.
  - stuck=1, duty 255, period 0, meas_valid pulses once.
  - Next rise clears stuck; the following rise yields a valid measurement.
REQ-030 Period 6, high 3 -> overrun pulse per rise, no meas_valid.
REQ-031 rst asserted 4 cycles after a completing rise -> no meas_valid, outputs 0.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// ----------------------------------------------------------------------------
// pwm_capture_pkg
//
// Purpose:
//   Shared definitions for the PWM capture block and its duty divider:
//   the capture FSM state enumeration, the number of divider iterations
//   (one per quotient bit) and the duty full-scale code.
//
// Contents:
//   cap_state_t  WAIT_RISE / HIGH / LOW capture states
//   DIV_ITER     restoring-divider iterations (8 -> 8-bit quotient)
//   DUTY_FULL    duty code reported for a line stuck high (255)
// ----------------------------------------------------------------------------
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } cap_state_t;

    localparam int         DIV_ITER  = 8;
    localparam logic [7:0] DUTY_FULL = 8'd255;

endpackage

// File: rtl/pwm_duty_div.sv
// ----------------------------------------------------------------------------
// pwm_duty_div
//
// Purpose:
//   Sequential restoring divider producing duty = floor(numerator*256 /
//   denominator) as an 8-bit code, one quotient bit per cclk cycle.
//   Because the caller guarantees numerator <= denominator, shifting the
//   partial remainder left once per iteration is the same as dividing
//   numerator*256; a numerator equal to the denominator saturates at 255.
//
// Ports:
//   cclk         clock, rising edge
//   rst          synchronous active-high reset; cancels any divide
//   start        load operands and begin; also restarts a busy divide
//   numerator    high time (CNT_W)
//   denominator  period (CNT_W)
//   busy         high while iterations are pending
//   done         one-cycle pulse, DIV_ITER cycles after start
//   quotient     8-bit duty result, valid when done is high
// ----------------------------------------------------------------------------
module pwm_duty_div
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = 17
) (
    input  logic             cclk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] numerator,
    input  logic [CNT_W-1:0] denominator,
    output logic             busy,
    output logic             done,
    output logic [7:0]       quotient
);

    localparam int ITER_W = $clog2(DIV_ITER + 1);

    logic [CNT_W-1:0]  rem_q;
    logic [CNT_W-1:0]  den_q;
    logic [ITER_W-1:0] iter_q;
    logic [CNT_W:0]    shifted;
    logic [CNT_W-1:0]  diff;
    logic              fits;

    // One restoring step. When the subtraction succeeds the true difference
    // is below the divisor, so the low CNT_W bits of the wrap-around
    // subtraction are exact.
    always_comb begin
        shifted = {rem_q, 1'b0};
        fits    = (shifted >= {1'b0, den_q});
        diff    = shifted[CNT_W-1:0] - den_q;
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            rem_q    <= '0;
            den_q    <= '0;
            iter_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q    <= numerator;
                den_q    <= denominator;
                iter_q   <= ITER_W'(DIV_ITER);
                busy     <= 1'b1;
                quotient <= '0;
            end else if (busy) begin
                rem_q    <= fits ? diff : shifted[CNT_W-1:0];
                quotient <= {quotient[6:0], fits};
                iter_q   <= iter_q - ITER_W'(1);
                if (iter_q == ITER_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// ----------------------------------------------------------------------------
// pwm_capture
//
// Purpose:
//   Measures an asynchronous PWM input: rise-to-rise period, high time and
//   the resulting duty on the 0..255 scale used by the PWM generator.
//   A measurement is published 11 cclk edges after the edge that first
//   samples the completing rise: 2 synchronizer edges, 1 edge to detect the
//   rise and capture, 8 divider iterations, 1 edge to publish.
//
// Ports:
//   cclk        clock, rising edge
//   rst         synchronous active-high reset
//   pwm_in      PWM waveform, asynchronous to cclk
//   duty_cycle  last measured duty, floor(high_time*256/period)
//   period      last measured rise-to-rise period in cclk cycles
//   high_time   last measured high time in cclk cycles
//   meas_valid  one-cycle pulse when the three results above update
//   stuck       level; no rise seen before the period counter saturated
//   overrun     one-cycle pulse; an in-flight measurement was discarded
// ----------------------------------------------------------------------------
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = 17
) (
    input  logic             cclk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [7:0]       duty_cycle,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stuck,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1;
    logic             sync2;
    logic             hist;
    logic             rise;
    logic             fall;

    cap_state_t       state_q;
    cap_state_t       state_d;

    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] hold_period;
    logic [CNT_W-1:0] hold_high;

    logic             capture;
    logic             latch_high;
    logic             timeout;

    logic             div_busy;
    logic             div_done;
    logic [7:0]       div_quot;
    logic             in_flight;

    // Two-flop synchronizer plus a history flop; edges are judged between
    // the synchronized stage and the history stage.
    always_ff @(posedge cclk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise = sync2 & ~hist;
    assign fall = ~sync2 & hist;

    // A measurement is in flight from capture until the cycle in which the
    // divider reports done; a rise anywhere in that window wins over the
    // pending publish.
    assign in_flight = div_busy | div_done;

    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q <= WAIT_RISE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A timeout only happens when no rise arrives on the
    // same edge, so a rise coinciding with saturation is still measured.
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        latch_high = 1'b0;
        timeout    = 1'b0;

        unique case (state_q)
            WAIT_RISE: begin
                if (rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d    = LOW;
                    latch_high = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    capture = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_RISE;
            end
        endcase

        if (!rise && (period_cnt == CNT_MAX) && !stuck) begin
            timeout    = 1'b1;
            latch_high = 1'b0;
            state_d    = WAIT_RISE;
        end
    end

    // Period counter restarts at 1 on every rise so that the value seen on
    // the next rise is the exact period; it saturates instead of wrapping.
    // The high counter snapshots it at the fall, giving the exact high time.
    always_ff @(posedge cclk) begin
        if (rst) begin
            period_cnt  <= '0;
            high_cnt    <= '0;
            hold_period <= '0;
            hold_high   <= '0;
        end else begin
            if (rise) begin
                period_cnt <= CNT_W'(1);
            end else if (period_cnt != CNT_MAX) begin
                period_cnt <= period_cnt + CNT_W'(1);
            end

            if (latch_high) begin
                high_cnt <= period_cnt;
            end

            if (capture) begin
                hold_period <= period_cnt;
                hold_high   <= high_cnt;
            end
        end
    end

    // The divider takes the live counts on the capture edge so that it
    // starts in parallel with the holding registers.
    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .cclk        (cclk),
        .rst         (rst),
        .start       (capture),
        .numerator   (high_cnt),
        .denominator (period_cnt),
        .busy        (div_busy),
        .done        (div_done),
        .quotient    (div_quot)
    );

    // Result registers. They hold between pulses; a timeout reports the
    // synchronized line level as full or zero duty and clears the counts.
    always_ff @(posedge cclk) begin
        if (rst) begin
            duty_cycle <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            stuck      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            overrun    <= capture & in_flight;

            if (rise) begin
                stuck <= 1'b0;
            end

            if (timeout) begin
                stuck      <= 1'b1;
                duty_cycle <= sync2 ? DUTY_FULL : 8'd0;
                period     <= '0;
                high_time  <= '0;
                meas_valid <= 1'b1;
            end else if (div_done && !capture) begin
                duty_cycle <= div_quot;
                period     <= hold_period;
                high_time  <= hold_high;
                meas_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// ----------------------------------------------------------------------------
// tb_pwm_capture
//
// Purpose:
//   Self-checking bench for pwm_capture. Drives cclk-synchronous PWM
//   waveforms (directed and random) and compares every output on every
//   cycle against an event-level reference model: a rise or fall is seen
//   two edges after pwm_in is first sampled at its new level, a completed
//   period publishes nine edges after that, results are plain integer
//   arithmetic. CNT_W is reduced to 12 so the saturation timeout is
//   reachable in a short run.
// ----------------------------------------------------------------------------
module tb_pwm_capture;

    localparam int CW  = 12;
    localparam int MAX = (1 << CW) - 1;

    logic          cclk;
    logic          rst;
    logic          pwm_in;
    logic [7:0]    duty_cycle;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          stuck;
    logic          overrun;

    pwm_capture #(
        .CNT_W (CW)
    ) dut (
        .cclk       (cclk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty_cycle (duty_cycle),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .stuck      (stuck),
        .overrun    (overrun)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int edgeNo = 0;
    bit h0 = 0, h1 = 0, h2 = 0;
    int phase = 0;
    int anchor = 0;
    int highLatched = 0;
    bit pendValid = 0;
    int pendDue = 0, pendPeriod = 0, pendHigh = 0;
    bit expValid = 0, expOverrun = 0, expStuck = 0;
    int expDuty = 0, expPeriod = 0, expHigh = 0;

    // Observation log
    int measCount = 0;
    int overrunCount = 0;
    int firstValidEdge = -1;
    int obsDuty = 0, obsPeriod = 0, obsHigh = 0;
    int riseLog[$];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edgeNo);
        end
    endtask

    task automatic modelEdge(input bit r, input bit lvl);
        bit d, dp, isRise, isFall;
        int cnt;
        expValid   = 0;
        expOverrun = 0;
        if (r) begin
            h0 = 0; h1 = 0; h2 = 0;
            phase = 0;
            anchor = edgeNo;
            pendValid = 0;
            expStuck = 0;
            expDuty = 0; expPeriod = 0; expHigh = 0;
            return;
        end
        d  = h1;
        dp = h2;
        h2 = h1; h1 = h0; h0 = lvl;
        isRise = d && !dp;
        isFall = !d && dp;
        cnt = edgeNo - 1 - anchor;
        if (cnt > MAX) cnt = MAX;
        if (isRise) begin
            if (phase == 2) begin
                if (pendValid) expOverrun = 1;
                pendValid  = 1;
                pendDue    = edgeNo + 9;
                pendPeriod = cnt;
                pendHigh   = highLatched;
            end
            expStuck = 0;
            phase = 1;
            anchor = edgeNo - 1;
        end else begin
            if (pendValid && edgeNo == pendDue) begin
                pendValid = 0;
                expValid  = 1;
                expPeriod = pendPeriod;
                expHigh   = pendHigh;
                expDuty   = (pendHigh >= pendPeriod) ? 255 : (pendHigh * 256) / pendPeriod;
            end
            if (!expStuck && cnt == MAX) begin
                expStuck  = 1;
                expValid  = 1;
                expDuty   = d ? 255 : 0;
                expPeriod = 0;
                expHigh   = 0;
                phase     = 0;
            end else if (isFall && phase == 1) begin
                highLatched = cnt;
                phase = 2;
            end
        end
    endtask

    task automatic checkOutput();
        checkVal("meas_valid", meas_valid, expValid);
        checkVal("overrun", overrun, expOverrun);
        checkVal("stuck", stuck, expStuck);
        checkVal("duty_cycle", duty_cycle, expDuty);
        checkVal("period", period, expPeriod);
        checkVal("high_time", high_time, expHigh);
        if (meas_valid === 1'b1) begin
            measCount++;
            if (firstValidEdge < 0) firstValidEdge = edgeNo;
            obsDuty   = duty_cycle;
            obsPeriod = period;
            obsHigh   = high_time;
        end
        if (overrun === 1'b1) overrunCount++;
    endtask

    task automatic applyStimulus(input bit lvl, input bit rstLvl);
        pwm_in = lvl;
        rst    = rstLvl;
        @(posedge cclk);
        edgeNo++;
        modelEdge(rstLvl, lvl);
        #1;
        checkOutput();
    endtask

    task automatic driveWave(input int highLen, input int periodLen, input int count);
        for (int c = 0; c < count; c++) begin
            for (int i = 0; i < periodLen; i++) begin
                applyStimulus(i < highLen, 1'b0);
                if (i == 0) riseLog.push_back(edgeNo);
            end
        end
    endtask

    initial begin
        int mark, omark;
        int p, hi, reps;
        rst    = 1'b1;
        pwm_in = 1'b0;

        $display("[TB] reset with toggling input");
        for (int i = 0; i < 5; i++) applyStimulus(i[0], 1'b1);
        checkVal("reset_meas_count", measCount, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);

        $display("[TB] period 256 high 64");
        riseLog.delete();
        firstValidEdge = -1;
        mark = measCount;
        driveWave(64, 256, 4);
        checkVal("p256_latency", firstValidEdge - riseLog[1], 11);
        checkVal("p256_count", measCount - mark, 3);
        checkVal("p256_duty", obsDuty, 64);
        checkVal("p256_period", obsPeriod, 256);
        checkVal("p256_high", obsHigh, 64);

        $display("[TB] period 1000 high 333");
        driveWave(333, 1000, 3);
        checkVal("p1000_duty", obsDuty, 85);
        checkVal("p1000_period", obsPeriod, 1000);
        checkVal("p1000_high", obsHigh, 333);

        $display("[TB] line held high until timeout");
        mark = measCount;
        for (int i = 0; i < MAX + 21; i++) applyStimulus(1'b1, 1'b0);
        checkVal("stuck_level", stuck, 1);
        checkVal("stuck_count", measCount - mark, 2);
        checkVal("stuck_duty", obsDuty, 255);
        checkVal("stuck_period", obsPeriod, 0);
        checkVal("stuck_high", obsHigh, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
        driveWave(20, 40, 3);
        checkVal("recover_stuck", stuck, 0);
        checkVal("recover_duty", obsDuty, 128);
        checkVal("recover_period", obsPeriod, 40);

        $display("[TB] period 6 high 3");
        mark  = measCount;
        omark = overrunCount;
        driveWave(3, 6, 10);
        checkVal("short_meas_count", measCount - mark, 0);
        checkVal("short_overrun_count", overrunCount - omark, 9);
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0);

        $display("[TB] reset during divide");
        driveWave(50, 100, 2);
        mark = measCount;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
        checkVal("rst_mid_count", measCount - mark, 0);
        checkVal("rst_mid_duty", duty_cycle, 0);
        checkVal("rst_mid_period", period, 0);

        $display("[TB] random waveforms");
        for (int s = 0; s < 25; s++) begin
            p    = $urandom_range(4, 200);
            hi   = $urandom_range(1, p - 1);
            reps = $urandom_range(1, 3);
            driveWave(hi, p, reps);
        end
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
